// File: rtl/seq_decoder_n2m_if.sv
// Request/response bundle for seq_decoder_n2m: load handshake, request fields and registered outputs.
// master drives requests; slave is the sequencer.
interface seq_decoder_n2m_if #(
   parameter int SEL_W  = 3,
   parameter int HOLD_W = 4
) ();
   localparam int OUT_W = 2 ** SEL_W;

   logic              en_n;
   logic              in_valid;
   logic              in_ready;
   logic              mode;
   logic [SEL_W-1:0]  sel;
   logic [HOLD_W-1:0] hold;
   logic [OUT_W-1:0]  y;
   logic              busy;
   logic              done;

   modport master (
      output en_n, in_valid, mode, sel, hold,
      input  in_ready, y, busy, done
   );

   modport slave (
      input  en_n, in_valid, mode, sel, hold,
      output in_ready, y, busy, done
   );
endinterface

// File: rtl/seq_decoder_n2m.sv
// Registered N-to-2^N one-hot output sequencer (direct hold or auto-scan); y/busy change one edge after accept.
// in_ready only in IDLE with en_n low; en_n high aborts. SEQ_DECODER_ACTIVE_LOW_OUT_EN makes y active-low.
module seq_decoder_n2m #(
   parameter int SEL_W  = 3,
   parameter int HOLD_W = 4
) (
   input logic               clk,
   input logic               rst,
   seq_decoder_n2m_if.slave  bus
);
   localparam int OUT_W = 2 ** SEL_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_SCAN = 2'd2;

`ifdef SEQ_DECODER_ACTIVE_LOW_OUT_EN
   localparam logic [OUT_W-1:0] Y_IDLE = '1;
`else
   localparam logic [OUT_W-1:0] Y_IDLE = '0;
`endif

   logic [1:0]        state;
   logic [HOLD_W-1:0] cnt;
   logic [HOLD_W-1:0] hold_q;
   logic [SEL_W-1:0]  idx;
   logic [SEL_W-1:0]  remaining;
   logic [OUT_W-1:0]  y_q;
   logic              busy_q;
   logic              done_q;
   logic              accept;

   // Polarity is folded in here so the rest of the logic is polarity-agnostic.
   function automatic logic [OUT_W-1:0] pick(input logic [SEL_W-1:0] i);
      pick = Y_IDLE ^ (OUT_W'(1) << i);
   endfunction

   assign bus.in_ready = (state == ST_IDLE) & ~bus.en_n & ~rst;
   assign accept       = bus.in_valid & bus.in_ready;
   assign bus.y        = y_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hold_q    <= '0;
         idx       <= '0;
         remaining <= '0;
         y_q       <= Y_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  y_q       <= pick(bus.sel);
                  busy_q    <= 1'b1;
                  cnt       <= bus.hold;
                  hold_q    <= bus.hold;
                  idx       <= bus.sel;
                  remaining <= bus.mode ? SEL_W'(OUT_W - 1) : '0;
                  state     <= bus.mode ? ST_SCAN : ST_HOLD;
               end
            end
            ST_HOLD, ST_SCAN: begin
               if (bus.en_n) begin
                  // Abort: drop the output immediately, never signal completion.
                  y_q    <= Y_IDLE;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - HOLD_W'(1);
               end else if (state == ST_SCAN && remaining != '0) begin
                  idx       <= idx + SEL_W'(1);
                  remaining <= remaining - SEL_W'(1);
                  cnt       <= hold_q;
                  y_q       <= pick(idx + SEL_W'(1));
               end else begin
                  y_q    <= Y_IDLE;
                  busy_q <= 1'b0;
                  done_q <= (state == ST_SCAN);
                  state  <= ST_IDLE;
               end
            end
            default: begin
               y_q    <= Y_IDLE;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
